// File: rtl/tri_raster_scan.sv
// Triangle scan-converter: clips the bounding box to the screen and walks it one
// pixel per cycle with add-only edge stepping, emitting covered pixels.
//
// state | meaning
// IDLE  | waiting for a triangle
// SETUP | clip bounding box, derive edge steps and area
// INIT  | evaluate edge functions at the box origin
// SCAN  | test one pixel per cycle, step edges
// FIN   | drain the last beat, pulse tri_done
module tri_raster_scan #(
    parameter int COORD_W  = 12,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int ADDR_W   = 26,
    parameter int COLOR_W  = 24,
    localparam int EDGE_W  = 2*COORD_W+3
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [COORD_W-1:0] x0,
    input  logic signed [COORD_W-1:0] y0,
    input  logic signed [COORD_W-1:0] x1,
    input  logic signed [COORD_W-1:0] y1,
    input  logic signed [COORD_W-1:0] x2,
    input  logic signed [COORD_W-1:0] y2,
    input  logic [COLOR_W-1:0]        color_in,
    input  logic [ADDR_W-1:0]         addr_base,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [COORD_W-1:0]        out_x,
    output logic [COORD_W-1:0]        out_y,
    output logic [ADDR_W-1:0]         out_addr,
    output logic signed [EDGE_W-1:0]  out_w0,
    output logic signed [EDGE_W-1:0]  out_w1,
    output logic signed [EDGE_W-1:0]  out_w2,
    output logic signed [EDGE_W-1:0]  out_area,
    output logic [COLOR_W-1:0]        out_color,
    output logic                      tri_done
);
    typedef enum logic [2:0] {IDLE, SETUP, INIT, SCAN, FIN} state_t;
    state_t state, state_next;

    localparam logic signed [COORD_W-1:0] X_LAST = COORD_W'(SCREEN_W-1);
    localparam logic signed [COORD_W-1:0] Y_LAST = COORD_W'(SCREEN_H-1);

    function automatic logic signed [EDGE_W-1:0] sext(input logic signed [COORD_W-1:0] v);
        return {{(EDGE_W-COORD_W){v[COORD_W-1]}}, v};
    endfunction

    function automatic logic signed [EDGE_W-1:0] edge_fn(
        input logic signed [COORD_W-1:0] xa, ya, xb, yb, px, py);
        return (sext(xb) - sext(xa)) * (sext(py) - sext(ya))
             - (sext(yb) - sext(ya)) * (sext(px) - sext(xa));
    endfunction

    function automatic logic signed [COORD_W-1:0] min3(input logic signed [COORD_W-1:0] a, b, c);
        logic signed [COORD_W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [COORD_W-1:0] max3(input logic signed [COORD_W-1:0] a, b, c);
        logic signed [COORD_W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    logic signed [COORD_W-1:0] vx0, vy0, vx1, vy1, vx2, vy2;
    logic [COLOR_W-1:0]        color_r;
    logic [ADDR_W-1:0]         base_r;
    logic signed [COORD_W-1:0] min_x, max_x, min_y, max_y, cur_x, cur_y;
    logic signed [EDGE_W-1:0]  area_r;
    logic signed [EDGE_W-1:0]  xstep [3];
    logic signed [EDGE_W-1:0]  ystep [3];
    logic signed [EDGE_W-1:0]  e     [3];
    logic signed [EDGE_W-1:0]  row_e [3];
    logic                      neg_r;
    logic [ADDR_W-1:0]         pix_addr, row_addr;

    logic signed [COORD_W-1:0] raw_min_x, raw_max_x, raw_min_y, raw_max_y;
    logic signed [EDGE_W-1:0]  setup_area;
    logic signed [EDGE_W-1:0]  dx_raw   [3];
    logic signed [EDGE_W-1:0]  dy_raw   [3];
    logic signed [EDGE_W-1:0]  e_origin [3];
    logic [ADDR_W-1:0]         origin_addr;
    logic box_empty, stall, covered, row_end, last_pixel, drained;

    // Edge k uses vertices (k+1, k+2): w0 = E_12, w1 = E_20, w2 = E_01.
    always_comb begin
        raw_min_x  = min3(vx0, vx1, vx2);
        raw_max_x  = max3(vx0, vx1, vx2);
        raw_min_y  = min3(vy0, vy1, vy2);
        raw_max_y  = max3(vy0, vy1, vy2);
        box_empty  = raw_max_x[COORD_W-1] || raw_max_y[COORD_W-1]
                  || (raw_min_x > X_LAST) || (raw_min_y > Y_LAST);
        setup_area = edge_fn(vx0, vy0, vx1, vy1, vx2, vy2);
        dx_raw[0]  = sext(vy1) - sext(vy2);
        dx_raw[1]  = sext(vy2) - sext(vy0);
        dx_raw[2]  = sext(vy0) - sext(vy1);
        dy_raw[0]  = sext(vx2) - sext(vx1);
        dy_raw[1]  = sext(vx0) - sext(vx2);
        dy_raw[2]  = sext(vx1) - sext(vx0);
        e_origin[0] = edge_fn(vx1, vy1, vx2, vy2, min_x, min_y);
        e_origin[1] = edge_fn(vx2, vy2, vx0, vy0, min_x, min_y);
        e_origin[2] = edge_fn(vx0, vy0, vx1, vy1, min_x, min_y);
        if (neg_r) begin
            e_origin[0] = -e_origin[0];
            e_origin[1] = -e_origin[1];
            e_origin[2] = -e_origin[2];
        end
        origin_addr = base_r + ADDR_W'($unsigned(min_y)) * ADDR_W'(SCREEN_W)
                    + ADDR_W'($unsigned(min_x));
        stall      = out_valid && !out_ready;
        covered    = !e[0][EDGE_W-1] && !e[1][EDGE_W-1] && !e[2][EDGE_W-1];
        row_end    = (cur_x == max_x);
        last_pixel = row_end && (cur_y == max_y);
        drained    = !out_valid || out_ready;
    end

    always_comb begin
        state_next = state;
        tri_done   = 1'b0;
        case (state)
            IDLE:  if (in_valid && in_ready) state_next = SETUP;
            SETUP: state_next = (box_empty || setup_area == '0) ? FIN : INIT;
            INIT:  state_next = SCAN;
            SCAN:  if (!stall && last_pixel) state_next = FIN;
            FIN: begin
                if (drained) begin
                    tri_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_addr  <= '0;
            out_w0    <= '0;
            out_w1    <= '0;
            out_w2    <= '0;
            out_area  <= '0;
            out_color <= '0;
        end else begin
            state    <= state_next;
            in_ready <= (state_next == IDLE);
            if (out_valid && out_ready) out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        vx0 <= x0; vy0 <= y0;
                        vx1 <= x1; vy1 <= y1;
                        vx2 <= x2; vy2 <= y2;
                        color_r <= color_in;
                        base_r  <= addr_base;
                    end
                end
                SETUP: begin
                    min_x  <= raw_min_x[COORD_W-1] ? '0 : raw_min_x;
                    min_y  <= raw_min_y[COORD_W-1] ? '0 : raw_min_y;
                    max_x  <= (raw_max_x > X_LAST) ? X_LAST : raw_max_x;
                    max_y  <= (raw_max_y > Y_LAST) ? Y_LAST : raw_max_y;
                    neg_r  <= setup_area[EDGE_W-1];
                    // Clockwise triangles are flipped so coverage is winding-independent.
                    area_r   <= setup_area[EDGE_W-1] ? -setup_area : setup_area;
                    xstep[0] <= setup_area[EDGE_W-1] ? -dx_raw[0] : dx_raw[0];
                    xstep[1] <= setup_area[EDGE_W-1] ? -dx_raw[1] : dx_raw[1];
                    xstep[2] <= setup_area[EDGE_W-1] ? -dx_raw[2] : dx_raw[2];
                    ystep[0] <= setup_area[EDGE_W-1] ? -dy_raw[0] : dy_raw[0];
                    ystep[1] <= setup_area[EDGE_W-1] ? -dy_raw[1] : dy_raw[1];
                    ystep[2] <= setup_area[EDGE_W-1] ? -dy_raw[2] : dy_raw[2];
                end
                INIT: begin
                    e        <= e_origin;
                    row_e    <= e_origin;
                    cur_x    <= min_x;
                    cur_y    <= min_y;
                    pix_addr <= origin_addr;
                    row_addr <= origin_addr;
                end
                SCAN: begin
                    if (!stall) begin
                        if (covered) begin
                            out_valid <= 1'b1;
                            out_x     <= cur_x;
                            out_y     <= cur_y;
                            out_addr  <= pix_addr;
                            out_w0    <= e[0];
                            out_w1    <= e[1];
                            out_w2    <= e[2];
                            out_area  <= area_r;
                            out_color <= color_r;
                        end
                        if (row_end) begin
                            cur_x    <= min_x;
                            cur_y    <= cur_y + COORD_W'(1);
                            row_addr <= row_addr + ADDR_W'(SCREEN_W);
                            pix_addr <= row_addr + ADDR_W'(SCREEN_W);
                            row_e[0] <= row_e[0] + ystep[0];
                            row_e[1] <= row_e[1] + ystep[1];
                            row_e[2] <= row_e[2] + ystep[2];
                            e[0]     <= row_e[0] + ystep[0];
                            e[1]     <= row_e[1] + ystep[1];
                            e[2]     <= row_e[2] + ystep[2];
                        end else begin
                            cur_x    <= cur_x + COORD_W'(1);
                            pix_addr <= pix_addr + ADDR_W'(1);
                            e[0]     <= e[0] + xstep[0];
                            e[1]     <= e[1] + xstep[1];
                            e[2]     <= e[2] + xstep[2];
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/tri_raster_scan.md
# tri_raster_scan

Parametrised triangle scan-converter that replaces the single-cycle bounding-box rasterizer in the 3D pipeline. It accepts one screen-space triangle per valid/ready transaction and clips its bounding box to the screen. It then walks the box one pixel per cycle using incrementally stepped edge functions, and emits each covered pixel with its frame-buffer address and raw barycentric weights. It sits between the vertex/setup stage and the interpolator/depth-test stage, and backpressure from downstream stalls the walk.

## Interface
- COORD_W, 12, signed vertex coordinate width (integer pixels)
- SCREEN_W, 640, screen width in pixels; also the frame-buffer row stride
- SCREEN_H, 480, screen height in pixels
- ADDR_W, 26, frame-buffer address width
- COLOR_W, 24, per-triangle colour tag width (passed through)
- EDGE_W (localparam), 2*COORD_W+3, edge-function and weight width, signed
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  triangle presented
- in_ready  out  1  block can accept a triangle
- x0,y0,x1,y1,x2,y2  in  COORD_W each  signed vertex coordinates
- color_in  in  COLOR_W  flat colour tag
- addr_base  in  ADDR_W  frame-buffer base address
- out_valid  out  1  pixel beat valid
- out_ready  in  1  downstream accepts the beat
- out_x, out_y  out  COORD_W  pixel coordinates (always in 0..SCREEN_W-1 / 0..SCREEN_H-1)
- out_addr  out  ADDR_W  addr_base + out_y*SCREEN_W + out_x, modulo 2^ADDR_W
- out_w0, out_w1, out_w2  out  EDGE_W  normalised weights for v0, v1, v2 (each ≥ 0)
- out_area  out  EDGE_W  normalised area, > 0, equals out_w0+out_w1+out_w2
- out_color  out  COLOR_W  colour tag of the current triangle
- tri_done  out  1  one-cycle pulse: triangle finished

## Operation
- Edge function: E_ab(p) = (xb-xa)(py-ya) - (yb-ya)(px-xa). Evaluate in EDGE_W signed arithmetic; operands are sign-extended before subtraction.
- Weight definitions: area = E_01(v2), w0 = E_12(p), w1 = E_20(p), w2 = E_01(p).
- Normalisation: if area < 0, negate area and all weights. Either winding therefore produces identical coverage.
- Coverage test: a pixel is covered iff all three normalised weights are ≥ 0, inclusive of edges, with no top-left rule.
- States:
  - IDLE: in_ready=1. A handshake latches all inputs and moves to SETUP.
  - SETUP: compute the bounding box clamped to [0,SCREEN_W-1]×[0,SCREEN_H-1], and compute the per-edge x-step -(yb-ya) and y-step (xb-xa). If the clamped box is empty or area==0, go to FIN; otherwise go to INIT.
  - INIT: evaluate the three edge functions and the area at (minX,minY), load the row-start registers, then go to SCAN.
  - SCAN: test the current pixel. If it is covered, load the output register. Then advance: add the x-step, or at x==maxX restore the row start plus the y-step and set x=minX, y++. After the pixel at (maxX,maxY) has been processed, go to FIN.
  - FIN: wait until the output register is empty, or its beat is accepted this cycle. Then pulse tri_done and return to IDLE.
- Stall: SCAN does not advance while out_valid && !out_ready. While stalled, all out_* signals hold stable.
- No multipliers are used in SCAN; stepping is add-only. SETUP/INIT may use multipliers.
- Reset mid-operation: on reset, abandon the triangle, drop any pending beat, and return to IDLE. No tri_done is generated.

## Timing
- Reset values: in_ready=0, out_valid=0, tri_done=0, and all out_* data = 0. in_ready rises the first cycle after reset deasserts.
- in_ready falls the cycle after the handshake and stays low until the cycle after the tri_done pulse.
- A handshake in cycle T gives SETUP in T+1, INIT in T+2, and the first SCAN test in T+3. The first covered pixel can assert out_valid in T+4.
- Throughput is one pixel tested per cycle while out_ready=1, so an unstalled triangle takes 3 + boxW*boxH cycles plus the FIN cycle.
- A degenerate or fully off-screen triangle pulses tri_done at T+2, which is FIN, and emits zero beats.
- tri_done is asserted in the same cycle as, or after, the acceptance of the final beat, never before it.
- A new in_valid may be accepted the cycle after tri_done.

## Test plan
- (0,0),(3,0),(0,3), base 0, out_ready=1 -> 10 beats, raster order (0,0),(1,0),(2,0),(3,0),(0,1)…(0,3). out_area=9; at (1,1), w0=3, w1=3, w2=3. Beat (0,3) has out_addr=1920. tri_done follows the last beat.
- Same triangle with the winding reversed, (0,0),(0,3),(3,0) -> the identical 10 pixels, out_area=9, and all weights ≥ 0.
- Clipping: (-2,0),(4,0),(-2,6) -> exactly 15 beats, every one with out_x ≥ 0 and x+y ≤ 4. A triangle entirely at x<0 -> 0 beats and tri_done at T+2.
- Degenerate collinear (0,0),(2,2),(4,4) -> 0 beats and tri_done at T+2. in_ready is back to 1 at T+3.
- Backpressure: first test triangle with out_ready toggled randomly and held low for 5 cycles mid-scan -> the same 10 beats in the same order, no duplicates, and outputs stable while stalled.
- Reset asserted during SCAN of a 100×100 triangle -> next cycle out_valid=0, tri_done=0, and in_ready=1 one cycle after release. A following small triangle rasterises correctly.
